scale_round_controller: RTL
===========================

# scale_round_controller

Frame-level sequencer for the multi-scale face-detection datapath. On each `start` it walks the image scaler through scale rounds 0..NUM_ROUNDS-1 and drives the scaler's `round_scale`, `en`, `finish` and `face_status` inputs. Within each round it launches the window detector once the scaler's line buffer reports full, and waits for both scaler end-of-scale and detector completion. It sits between the top-level frame control and the scaler/detector pair.

## Interface
Parameters:
- `NUM_ROUNDS`, 18: number of scale rounds per frame (scale index 0..17).
- `ROUND_W`, 5: width of `round_scale`.
- `CNT_W`, 8: width of `face_count`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `abort` in 1: cancel the frame; honoured in any non-IDLE state.
- `scaler_end` in 1: scaler `endScale`; request address has hit the round limit.
- `scaler_full` in 1: scaler `full`; line buffer holds enough lines for detection.
- `detect_done` in 1: one-cycle pulse from the detector; the round's windows are finished.
- `face_found` in 1: valid with `detect_done`; at least one face found in this round.
- `round_scale` out ROUND_W: current scale index, drives the scaler.
- `scaler_en` out 1: drives scaler `en`.
- `scaler_finish` out 1: drives scaler `finish`.
- `scaler_face_status` out 1: drives scaler `face_status`; high while the detector is running.
- `detect_start` out 1: one-cycle launch pulse to the detector.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when all rounds complete.
- `face_count` out CNT_W: number of rounds with `face_found`; saturating; held after the frame until the next `start`.

## Operation
- States: IDLE, SCALE, WAIT_DET, NEXT, DONE. All outputs are registered.
- IDLE
  - All outputs 0; `face_count` holds its last value.
  - On `start`: go to SCALE; set `round_scale`=0; clear `face_count`, `launched` and `det_done`.
- SCALE
  - `scaler_en`=1.
  - First cycle `scaler_full`=1 with `launched`=0: pulse `detect_start` and set `launched`.
  - `detect_done` sets `det_done`.
  - On `scaler_end`=1:
    - `launched` & (`det_done` | `detect_done`): go to NEXT.
    - Otherwise: go to WAIT_DET. If not yet launched, pulse `detect_start` on entry (covers small scales where the round ends before `full`).
- WAIT_DET
  - `scaler_en`=1, `scaler_finish`=1.
  - On `detect_done` (or `det_done` already set): go to NEXT.
- NEXT
  - `scaler_en`=0 for exactly one cycle; this clears the scaler address.
  - Clear `launched` and `det_done`.
  - If `round_scale`==NUM_ROUNDS-1: go to DONE. Else increment `round_scale` and go to SCALE.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- `scaler_face_status` = `launched` & !`det_done`, and forced 0 outside SCALE/WAIT_DET.
- `face_count` increments on every `detect_done`&`face_found` seen in SCALE/WAIT_DET; it saturates at 2^CNT_W-1.
- A `detect_done` seen while `launched`=0 is ignored.

## Timing
- Reset: state IDLE; `round_scale`=0; `face_count`=0; every 1-bit output 0.
- `rst` dominates `abort`; `abort` dominates `start` and all other transitions.
- `start` at cycle t → `busy`=`scaler_en`=1, `round_scale`=0 at t+1.
- `scaler_full` first seen high at cycle k → `detect_start` high at k+1 only.
- `scaler_end` at cycle e with detection already done → NEXT at e+1 (`scaler_en`=0) → SCALE with `round_scale`+1 at e+2.
- Minimum inter-round gap: one cycle with `scaler_en` low.
- Same-cycle `detect_done` and `scaler_end` in SCALE: treated as done; go to NEXT; the count still increments.
- `abort` or `rst` mid-frame → IDLE next cycle; `scaler_en`=0, no `frame_done`, `face_count` keeps its partial value.
- `start` while `busy` is ignored.

## Structure
- Package `scaler_ctrl_pkg`: state enum, `NUM_ROUNDS`=18, `ROUND_W`=5, `CNT_W`=8.
- Single FSM module. The saturating face counter is the one natural sub-module: `sat_counter` (parameter width; inc, clr).

## Test plan
- Nominal frame: `start`; model `scaler_full` 5 cycles after each SCALE entry, `scaler_end` 20 cycles later, `detect_done` 3 cycles after `scaler_end` → 18 rounds with `round_scale` 0..17 in order, 18 `detect_start` pulses, `frame_done` exactly once, `busy` drops the cycle after.
- Detector early: `detect_done` before `scaler_end` → no WAIT_DET; `scaler_finish` never asserted; NEXT the cycle after `scaler_end`.
- No full: `scaler_end` with `scaler_full` never high → `detect_start` pulsed on WAIT_DET entry; round advances after `detect_done`.
- Faces: `face_found`=1 in rounds 2, 7, 17 → `face_count`=3 at `frame_done`. Force 300 hits with `CNT_W`=8 → saturates at 255.
- Abort in round 9 WAIT_DET → IDLE next cycle, `scaler_en`=0, no `frame_done`. A new `start` restarts at round 0 with `face_count`=0.
- `rst` asserted mid-SCALE, and `start` held high while `busy` → all outputs at reset values next cycle; a held `start` during a frame causes no restart.

Source files
------------

// File: rtl/scaler_ctrl_pkg.sv
// Shared constants for the scale-round controller: default sizing and FSM state encodings.
package scaler_ctrl_pkg;

   localparam int unsigned NUM_ROUNDS = 18;
   localparam int unsigned ROUND_W    = 5;
   localparam int unsigned CNT_W      = 8;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StScale   = 3'd1;
   localparam logic [2:0] StWaitDet = 3'd2;
   localparam logic [2:0] StNext    = 3'd3;
   localparam logic [2:0] StDone    = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/scale_round_controller.sv
// Frame sequencer: steps the image scaler through every scale round and launches the
// window detector once per round, counting the rounds in which a face was found.
module scale_round_controller #(
   parameter int unsigned NUM_ROUNDS = scaler_ctrl_pkg::NUM_ROUNDS,
   parameter int unsigned ROUND_W    = scaler_ctrl_pkg::ROUND_W,
   parameter int unsigned CNT_W      = scaler_ctrl_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               scaler_end,
   input  logic               scaler_full,
   input  logic               detect_done,
   input  logic               face_found,
   output logic [ROUND_W-1:0] round_scale,
   output logic               scaler_en,
   output logic               scaler_finish,
   output logic               scaler_face_status,
   output logic               detect_start,
   output logic               busy,
   output logic               frame_done,
   output logic [CNT_W-1:0]   face_count
);

   import scaler_ctrl_pkg::*;

   localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS - 1);

   logic [2:0]         state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               launched_q, launched_d;
   logic               det_done_q, det_done_d;
   logic               dstart_d;
   logic               det_seen;
   logic               cnt_clr, cnt_inc;
   logic               in_round_d;

   logic en_q, finish_q, status_q, dstart_q, busy_q, fdone_q;

   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      launched_d = launched_q;
      det_done_d = det_done_q;
      dstart_d   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      // A completion from a detector that was never launched this round is stale.
      det_seen   = detect_done && launched_q;

      if ((state_q != StIdle) && abort) begin
         state_d    = StIdle;
         round_d    = '0;
         launched_d = 1'b0;
         det_done_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_d    = StScale;
                  round_d    = '0;
                  cnt_clr    = 1'b1;
                  launched_d = 1'b0;
                  det_done_d = 1'b0;
               end
            end
            StScale: begin
               cnt_inc = det_seen && face_found;
               if (det_seen) begin
                  det_done_d = 1'b1;
               end
               if (scaler_end) begin
                  if (launched_q && (det_done_q || detect_done)) begin
                     state_d = StNext;
                  end else begin
                     state_d = StWaitDet;
                     // Small scales can end before the line buffer ever fills.
                     if (!launched_q) begin
                        dstart_d   = 1'b1;
                        launched_d = 1'b1;
                     end
                  end
               end else if (scaler_full && !launched_q) begin
                  dstart_d   = 1'b1;
                  launched_d = 1'b1;
               end
            end
            StWaitDet: begin
               cnt_inc = det_seen && face_found;
               if (det_seen) begin
                  det_done_d = 1'b1;
               end
               if (det_done_q || det_seen) begin
                  state_d = StNext;
               end
            end
            StNext: begin
               launched_d = 1'b0;
               det_done_d = 1'b0;
               if (round_q == LastRound) begin
                  state_d = StDone;
               end else begin
                  round_d = round_q + ROUND_W'(1);
                  state_d = StScale;
               end
            end
            StDone: begin
               state_d = StIdle;
               round_d = '0;
            end
            default: begin
               state_d = StIdle;
               round_d = '0;
            end
         endcase
      end
   end

   assign in_round_d = (state_d == StScale) || (state_d == StWaitDet);

   // Outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         round_q    <= '0;
         launched_q <= 1'b0;
         det_done_q <= 1'b0;
         en_q       <= 1'b0;
         finish_q   <= 1'b0;
         status_q   <= 1'b0;
         dstart_q   <= 1'b0;
         busy_q     <= 1'b0;
         fdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         launched_q <= launched_d;
         det_done_q <= det_done_d;
         en_q       <= in_round_d;
         finish_q   <= (state_d == StWaitDet);
         status_q   <= in_round_d && launched_d && !det_done_d;
         dstart_q   <= dstart_d;
         busy_q     <= (state_d != StIdle);
         fdone_q    <= (state_d == StDone);
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_face_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (face_count)
   );

   assign round_scale        = round_q;
   assign scaler_en          = en_q;
   assign scaler_finish      = finish_q;
   assign scaler_face_status = status_q;
   assign detect_start       = dstart_q;
   assign busy               = busy_q;
   assign frame_done         = fdone_q;

endmodule
